// File: rtl/axil_slav_pkg.sv
// Shared constants and state encodings for the AXI-Lite slave router.
// Imported by the top and by the timeout counter.
package axil_slav_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        W_IDLE,
        W_FWD,
        W_RESP
    } wr_state_t;

    typedef enum logic [1:0] {
        R_IDLE,
        R_ADDR,
        R_DATA,
        R_RESP
    } rd_state_t;

endpackage

// File: rtl/axil_timeout_cnt.sv
// Saturating per-engine watchdog: cleared on state entry, counts while enabled,
// flags expiry once pTIMEOUT cycles have elapsed.
module axil_timeout_cnt
    import axil_slav_pkg::*;
#(
    parameter int pTIMEOUT = 255
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int CW = $clog2(pTIMEOUT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(pTIMEOUT);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != LIMIT)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q == LIMIT);

endmodule

// File: rtl/axil_slav_router.sv
// AXI-Lite slave router: one upstream slave port fanned out to pNUM_PRJ user
// projects, with independent read/write engines, decode error and timeout.
module axil_slav_router
    import axil_slav_pkg::*;
#(
    parameter int pADDR_WIDTH = 12,
    parameter int pDATA_WIDTH = 32,
    parameter int pNUM_PRJ    = 4,
    parameter int pSEL_WIDTH  = 2,
    parameter int pTIMEOUT    = 255
) (
    input  logic                            ALCLK,
    input  logic                            ARESET,
    input  logic [pSEL_WIDTH-1:0]           USER_PRJ_SEL,
    // upstream write
    input  logic [pADDR_WIDTH-1:0]          a_ls_awaddr,
    input  logic                            a_ls_awvalid,
    output logic                            a_ls_awready,
    input  logic [pDATA_WIDTH-1:0]          a_ls_wdata,
    input  logic [pDATA_WIDTH/8-1:0]        a_ls_wstrb,
    input  logic                            a_ls_wvalid,
    output logic                            a_ls_wready,
    output logic [1:0]                      a_ls_bresp,
    output logic                            a_ls_bvalid,
    input  logic                            a_ls_bready,
    // upstream read
    input  logic [pADDR_WIDTH-1:0]          a_ls_araddr,
    input  logic                            a_ls_arvalid,
    output logic                            a_ls_arready,
    output logic [pDATA_WIDTH-1:0]          a_ls_rdata,
    output logic [1:0]                      a_ls_rresp,
    output logic                            a_ls_rvalid,
    input  logic                            a_ls_rready,
    // downstream projects
    output logic [pADDR_WIDTH-1:0]          awaddr,
    output logic [pADDR_WIDTH-1:0]          araddr,
    output logic [pDATA_WIDTH-1:0]          wdata,
    output logic [pDATA_WIDTH/8-1:0]        wstrb,
    output logic [pNUM_PRJ-1:0]             awvalid,
    output logic [pNUM_PRJ-1:0]             wvalid,
    output logic [pNUM_PRJ-1:0]             arvalid,
    output logic [pNUM_PRJ-1:0]             rready,
    input  logic [pNUM_PRJ-1:0]             awready,
    input  logic [pNUM_PRJ-1:0]             wready,
    input  logic [pNUM_PRJ-1:0]             arready,
    input  logic [pNUM_PRJ-1:0]             rvalid,
    input  logic [pNUM_PRJ*pDATA_WIDTH-1:0] rdata
);

    localparam int SW = pDATA_WIDTH / 8;

    // An out-of-range select decodes to all zeros, which doubles as the range check.
    function automatic logic [pNUM_PRJ-1:0] sel_onehot(input logic [pSEL_WIDTH-1:0] sel);
        logic [pNUM_PRJ-1:0] oh;
        oh = '0;
        for (int i = 0; i < pNUM_PRJ; i++) begin
            if (int'(sel) == i) oh[i] = 1'b1;
        end
        return oh;
    endfunction

    // ---------------- write engine ----------------
    wr_state_t               wr_state_q, wr_state_d;
    logic                    aw_held_q, aw_held_d;
    logic                    w_held_q, w_held_d;
    logic                    aw_done_q, aw_done_d;
    logic                    w_done_q, w_done_d;
    logic [pADDR_WIDTH-1:0]  awaddr_q, awaddr_d;
    logic [pDATA_WIDTH-1:0]  wdata_q, wdata_d;
    logic [SW-1:0]           wstrb_q, wstrb_d;
    logic [pSEL_WIDTH-1:0]   wsel_q, wsel_d;
    logic [1:0]              bresp_q, bresp_d;
    logic [pNUM_PRJ-1:0]     wsel_oh;
    logic                    aw_hs, w_hs, wr_expired;

    assign wsel_oh = sel_onehot(wsel_q);
    assign aw_hs   = a_ls_awvalid && a_ls_awready;
    assign w_hs    = a_ls_wvalid && a_ls_wready;

    always_ff @(posedge ALCLK) begin
        if (ARESET) begin
            wr_state_q <= W_IDLE;
            aw_held_q  <= 1'b0;
            w_held_q   <= 1'b0;
            aw_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
            awaddr_q   <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            wsel_q     <= '0;
            bresp_q    <= RESP_OKAY;
        end else begin
            wr_state_q <= wr_state_d;
            aw_held_q  <= aw_held_d;
            w_held_q   <= w_held_d;
            aw_done_q  <= aw_done_d;
            w_done_q   <= w_done_d;
            awaddr_q   <= awaddr_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            wsel_q     <= wsel_d;
            bresp_q    <= bresp_d;
        end
    end

    always_comb begin
        wr_state_d = wr_state_q;
        aw_held_d  = aw_held_q;
        w_held_d   = w_held_q;
        aw_done_d  = aw_done_q;
        w_done_d   = w_done_q;
        awaddr_d   = awaddr_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        wsel_d     = wsel_q;
        bresp_d    = bresp_q;
        case (wr_state_q)
            W_IDLE: begin
                if (aw_hs) begin
                    aw_held_d = 1'b1;
                    awaddr_d  = a_ls_awaddr;
                end
                if (w_hs) begin
                    w_held_d = 1'b1;
                    wdata_d  = a_ls_wdata;
                    wstrb_d  = a_ls_wstrb;
                end
                // Launch as soon as both halves are in hand, including this cycle's captures.
                if ((aw_held_q || aw_hs) && (w_held_q || w_hs)) begin
                    wsel_d    = USER_PRJ_SEL;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    if (|sel_onehot(USER_PRJ_SEL)) begin
                        wr_state_d = W_FWD;
                    end else begin
                        bresp_d    = RESP_DECERR;
                        wr_state_d = W_RESP;
                    end
                end
            end
            W_FWD: begin
                aw_done_d = aw_done_q || (|(awready & wsel_oh));
                w_done_d  = w_done_q || (|(wready & wsel_oh));
                if (aw_done_d && w_done_d) begin
                    bresp_d    = RESP_OKAY;
                    wr_state_d = W_RESP;
                end else if (wr_expired) begin
                    bresp_d    = RESP_SLVERR;
                    wr_state_d = W_RESP;
                end
            end
            W_RESP: begin
                if (a_ls_bready) begin
                    aw_held_d  = 1'b0;
                    w_held_d   = 1'b0;
                    wr_state_d = W_IDLE;
                end
            end
            default: wr_state_d = W_IDLE;
        endcase
    end

    always_comb begin
        a_ls_awready = !ARESET && (wr_state_q == W_IDLE) && !aw_held_q;
        a_ls_wready  = !ARESET && (wr_state_q == W_IDLE) && !w_held_q;
        a_ls_bvalid  = (wr_state_q == W_RESP);
        a_ls_bresp   = bresp_q;
        awvalid      = ((wr_state_q == W_FWD) && !aw_done_q) ? wsel_oh : '0;
        wvalid       = ((wr_state_q == W_FWD) && !w_done_q) ? wsel_oh : '0;
        awaddr       = awaddr_q;
        wdata        = wdata_q;
        wstrb        = wstrb_q;
    end

    axil_timeout_cnt #(.pTIMEOUT(pTIMEOUT)) u_wr_timer (
        .clk_i     (ALCLK),
        .rst_i     (ARESET),
        .clr_i     (wr_state_d != wr_state_q),
        .en_i      (wr_state_q == W_FWD),
        .expired_o (wr_expired)
    );

    // ---------------- read engine ----------------
    rd_state_t               rd_state_q, rd_state_d;
    logic [pADDR_WIDTH-1:0]  araddr_q, araddr_d;
    logic [pSEL_WIDTH-1:0]   rsel_q, rsel_d;
    logic [pDATA_WIDTH-1:0]  rdata_q, rdata_d;
    logic [1:0]              rresp_q, rresp_d;
    logic [pNUM_PRJ-1:0]     rsel_oh;
    logic [pDATA_WIDTH-1:0]  rdata_sel;
    logic                    rd_expired;

    assign rsel_oh = sel_onehot(rsel_q);

    always_comb begin
        rdata_sel = '0;
        for (int i = 0; i < pNUM_PRJ; i++) begin
            if (rsel_oh[i]) rdata_sel = rdata[i*pDATA_WIDTH +: pDATA_WIDTH];
        end
    end

    always_ff @(posedge ALCLK) begin
        if (ARESET) begin
            rd_state_q <= R_IDLE;
            araddr_q   <= '0;
            rsel_q     <= '0;
            rdata_q    <= '0;
            rresp_q    <= RESP_OKAY;
        end else begin
            rd_state_q <= rd_state_d;
            araddr_q   <= araddr_d;
            rsel_q     <= rsel_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
        end
    end

    always_comb begin
        rd_state_d = rd_state_q;
        araddr_d   = araddr_q;
        rsel_d     = rsel_q;
        rdata_d    = rdata_q;
        rresp_d    = rresp_q;
        case (rd_state_q)
            R_IDLE: begin
                if (a_ls_arvalid && a_ls_arready) begin
                    araddr_d = a_ls_araddr;
                    rsel_d   = USER_PRJ_SEL;
                    if (|sel_onehot(USER_PRJ_SEL)) begin
                        rd_state_d = R_ADDR;
                    end else begin
                        rdata_d    = '0;
                        rresp_d    = RESP_DECERR;
                        rd_state_d = R_RESP;
                    end
                end
            end
            R_ADDR: begin
                if (|(arready & rsel_oh)) begin
                    rd_state_d = R_DATA;
                end else if (rd_expired) begin
                    rdata_d    = '0;
                    rresp_d    = RESP_SLVERR;
                    rd_state_d = R_RESP;
                end
            end
            R_DATA: begin
                if (|(rvalid & rsel_oh)) begin
                    rdata_d    = rdata_sel;
                    rresp_d    = RESP_OKAY;
                    rd_state_d = R_RESP;
                end else if (rd_expired) begin
                    rdata_d    = '0;
                    rresp_d    = RESP_SLVERR;
                    rd_state_d = R_RESP;
                end
            end
            R_RESP: begin
                if (a_ls_rready) rd_state_d = R_IDLE;
            end
            default: rd_state_d = R_IDLE;
        endcase
    end

    always_comb begin
        a_ls_arready = !ARESET && (rd_state_q == R_IDLE);
        a_ls_rvalid  = (rd_state_q == R_RESP);
        a_ls_rdata   = rdata_q;
        a_ls_rresp   = rresp_q;
        arvalid      = (rd_state_q == R_ADDR) ? rsel_oh : '0;
        rready       = (rd_state_q == R_DATA) ? rsel_oh : '0;
        araddr       = araddr_q;
    end

    axil_timeout_cnt #(.pTIMEOUT(pTIMEOUT)) u_rd_timer (
        .clk_i     (ALCLK),
        .rst_i     (ARESET),
        .clr_i     (rd_state_d != rd_state_q),
        .en_i      ((rd_state_q == R_ADDR) || (rd_state_q == R_DATA)),
        .expired_o (rd_expired)
    );

endmodule
